cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
Controller in front of the CNN accelerator's per-region RAMs (input image + 4 layer weight buffers) and its 4 layer engines. It accepts byte-stream loads from the Avalon-MM slave port and steers them to the right RAM with auto-incrementing addresses. It tracks load completion, then runs layers 1..4 in order with start/done handshakes. It exposes status and sequential readout of the 53-byte classifier result.

Parameters:
ADDR_W, 19, width of every RAM address
IN_SIZE, 10000, input image bytes (region 0)
L1_SIZE, 400, layer-1 conv weight bytes (region 1)
L2_SIZE, 12800, layer-2 conv weight bytes (region 2)
L3_SIZE, 230400, layer-3 FC weight bytes (region 3)
L4_SIZE, 10600, layer-4 FC weight bytes (region 4)
OUT_SIZE, 53, result bytes readable after the run

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  0-4 = load region, 5 = status, 6 = result stream, 7 = command
writedata  in  8  load byte / command byte
readdata  out  8  registered read data
mem_we  out  5  one-hot write enable per region RAM
mem_addr  out  ADDR_W  write address (shared by all regions)
mem_wdata  out  8  write byte
layer_start  out  4  one-cycle start pulse per layer
layer_done  in  4  one-cycle done pulse per layer
out_rd_addr  out  ADDR_W  result RAM read address
out_rd_data  in  8  result RAM data (1-cycle registered-read latency)

Behaviour:
- Reset: state=LOAD, loaded=0, all counters=0, err=0, out ptr=0. Outputs readdata=0, mem_we=0, mem_addr=0, mem_wdata=0, layer_start=0, out_rd_addr=0.
- States: LOAD -> RUN(k), k=0..3 -> DONE.
- LOAD handling for a write to region r (0-4) with loaded[r]=0:
  - Next cycle: mem_we[r]=1, mem_addr=cnt[r], mem_wdata=writedata (1-cycle latency).
  - cnt[r] increments. When cnt[r] reaches SIZE_r-1 on a write, set loaded[r] and hold cnt[r].
  - A write to a region with loaded[r]=1 is dropped, no mem_we, and sets sticky err.
  - Back-to-back writes accepted every cycle.
- LOAD -> RUN(0): in the cycle after loaded==5'b11111; layer_start[0] pulses in that same cycle.
- RUN(k):
  - Waits for layer_done[k].
  - On layer_done[k], k<3: go to RUN(k+1) and pulse layer_start[k+1] next cycle.
  - On layer_done[3]: go to DONE.
  - layer_done bits other than k are ignored and set err.
  - Load writes during RUN/DONE are dropped and set err.
- Status read (address 5), any state: readdata = {busy, done, err, loaded[4:0]}, valid the cycle after read. busy = state is RUN.
- Result read (address 6):
  - In DONE: readdata = out_rd_data, then ptr increments and wraps OUT_SIZE-1 -> 0. out_rd_addr = ptr at all times.
  - Reads to address 6 must be >=2 cycles apart; a closer read returns the previous byte. This is defined behaviour and must not be "fixed".
  - Outside DONE: readdata = 0x00 and ptr unchanged.
- Command write (address 7), accepted in any state:
  - bit0 = full restart: loaded=0, all cnt=0, err=0, ptr=0, state=LOAD.
  - bit1 = rerun: clears loaded[0]/cnt[0] and ptr only, state=LOAD. Weights are kept, so a new image alone triggers the next run.
  - bit0 has priority over bit1. A restart in RUN abandons the run; a late layer_done is ignored with no err.
- Reads to addresses 0-4 and 7 return 0x00. Simultaneous read and write asserted: write processed, readdata=0x00.
- reset at any cycle overrides everything, including a pending start pulse.
- Counter width is ADDR_W. Sizes must be <=2^ADDR_W, checked by an elaboration assertion.

Decomposition:
- cnn_pkg:
  - Region index constants (REG_IN=0 .. REG_L4=4).
  - Address map constants (ADDR_STATUS=5, ADDR_RESULT=6, ADDR_CMD=7).
  - State enum seq_state_t {LOAD, RUN, DONE}.
  - Status bit positions.
- Sub-module region_load_counter: per-region counter + loaded flag with clear/inc/size ports, instantiated 5 times.

Test Plan:
- Small sizes (IN=4, L1..L4=2, OUT=3), 4 writes to addr 0 of 0x11..0x14 -> mem_we[0] one cycle after each write, mem_addr 0..3, status=0x01.
- Load all regions -> layer_start[0] pulses exactly once; done[0..2] -> start[1..3] each 1 cycle later; done[3] -> status=0x5F.
- In DONE, read addr 6 four times, 2 cycles apart, out RAM={0xA0,0xA1,0xA2} -> 0xA0,0xA1,0xA2,0xA0 (wrap).
- Extra write to full region 1, plus layer_done[2] during RUN(0) -> no mem_we, err=1, state stays RUN(0).
- After DONE, cmd 0x02 then 4 input writes -> only region 0 reloaded, layer_start[0] pulses, weights untouched.
- reset asserted mid-RUN(1) -> next cycle all outputs 0, status=0x00; a later layer_done[1] is ignored.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer sequencer.
//   - region indices of the five load RAMs (input image + four weight buffers)
//   - Avalon address map for the non-load addresses
//   - sequencer state encoding
//   - bit positions inside the status byte and the command byte
package cnn_pkg;

  localparam int N_REGIONS = 5;
  localparam int N_LAYERS  = 4;

  // Load regions, addressed directly by the Avalon address.
  localparam logic [2:0] REG_IN = 3'd0;
  localparam logic [2:0] REG_L1 = 3'd1;
  localparam logic [2:0] REG_L2 = 3'd2;
  localparam logic [2:0] REG_L3 = 3'd3;
  localparam logic [2:0] REG_L4 = 3'd4;

  // Remaining Avalon addresses.
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_RESULT = 3'd6;
  localparam logic [2:0] ADDR_CMD    = 3'd7;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Status byte: {busy, done, err, loaded[4:0]}.
  localparam int STAT_BUSY = 7;
  localparam int STAT_DONE = 6;
  localparam int STAT_ERR  = 5;

  // Command byte bits.
  localparam int CMD_RESTART = 0;
  localparam int CMD_RERUN   = 1;

  function automatic logic is_region_addr(input logic [2:0] addr);
    return addr <= REG_L4;
  endfunction

endpackage

// File: rtl/region_load_counter.sv
// Write-address counter and "loaded" flag for one load region.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : return to empty (cnt = 0, loaded = 0)
//   inc        : one byte written at address cnt this cycle
//   cnt        : address the next accepted byte goes to
//   loaded     : all SIZE bytes have been written; cnt then holds at SIZE-1
module region_load_counter #(
  parameter int ADDR_W = 19,
  parameter int SIZE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              loaded
);

  if (SIZE < 1 || longint'(SIZE) > (longint'(1) << ADDR_W)) begin : g_size_check
    $error("region_load_counter: SIZE must be in 1..2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (inc && !loaded) begin
      if (cnt == LAST) begin
        loaded <= 1'b1;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Controller in front of the CNN accelerator RAMs and layer engines.
//   Avalon slave (chipselect/write/read/address/writedata/readdata):
//     0-4 write : byte into load region, auto-incrementing address
//     5   read  : status {busy, done, err, loaded[4:0]}
//     6   read  : next classifier result byte (only in DONE)
//     7   write : command, bit0 = full restart, bit1 = rerun with new image
//   mem_we/mem_addr/mem_wdata : registered write port to the region RAMs
//   layer_start/layer_done    : per-layer one-cycle handshake pulses
//   out_rd_addr/out_rd_data   : result RAM read port (1-cycle read latency)
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int IN_SIZE  = 10000,
  parameter int L1_SIZE  = 400,
  parameter int L2_SIZE  = 12800,
  parameter int L3_SIZE  = 230400,
  parameter int L4_SIZE  = 10600,
  parameter int OUT_SIZE = 53
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic [4:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        layer_start,
  input  logic [3:0]        layer_done,
  output logic [ADDR_W-1:0] out_rd_addr,
  input  logic [7:0]        out_rd_data
);

  if (OUT_SIZE < 1 || longint'(OUT_SIZE) > (longint'(1) << ADDR_W)) begin : g_out_size_check
    $error("cnn_layer_sequencer: OUT_SIZE must be in 1..2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_SIZE - 1);

  // ---------------------------------------------------------------------------
  // Bus decode. A cycle with both strobes is treated as a write only.
  // ---------------------------------------------------------------------------
  logic wr_req, rd_only, ld_wr, cmd_wr, cmd_restart, cmd_rerun;

  assign wr_req      = chipselect & write;
  assign rd_only     = chipselect & read & ~write;
  assign ld_wr       = wr_req & is_region_addr(address);
  assign cmd_wr      = wr_req & (address == ADDR_CMD);
  assign cmd_restart = cmd_wr & writedata[CMD_RESTART];
  // Restart already covers everything a rerun clears.
  assign cmd_rerun   = cmd_wr & ~writedata[CMD_RESTART] & writedata[CMD_RERUN];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  seq_state_t        state, state_next;
  logic [1:0]        layer_idx, layer_next;
  logic [3:0]        start_next;
  logic              err, err_next;
  logic [ADDR_W-1:0] ptr, ptr_next;

  // ---------------------------------------------------------------------------
  // Region counters
  // ---------------------------------------------------------------------------
  logic [N_REGIONS-1:0] loaded, cnt_clear, cnt_inc;
  logic [ADDR_W-1:0]    cnt [N_REGIONS];
  logic [ADDR_W-1:0]    sel_cnt;
  logic                 sel_loaded, ld_accept, ld_drop;

  for (genvar r = 0; r < N_REGIONS; r++) begin : g_region
    localparam int SIZE = (r == 0) ? IN_SIZE :
                          (r == 1) ? L1_SIZE :
                          (r == 2) ? L2_SIZE :
                          (r == 3) ? L3_SIZE : L4_SIZE;

    // A rerun only forgets the image; the weight regions stay loaded.
    assign cnt_clear[r] = cmd_restart | (cmd_rerun & (r == 0));
    assign cnt_inc[r]   = ld_accept & (address == 3'(r));

    region_load_counter #(
      .ADDR_W (ADDR_W),
      .SIZE   (SIZE)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear[r]),
      .inc    (cnt_inc[r]),
      .cnt    (cnt[r]),
      .loaded (loaded[r])
    );
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_cnt    = '0;
    sel_loaded = 1'b1;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (address == 3'(r)) begin
        sel_cnt    = cnt[r];
        sel_loaded = loaded[r];
      end
    end
  end

  // Loads are only taken while loading, and only until the region is full.
  assign ld_accept = ld_wr & (state == LOAD) & ~sel_loaded;
  assign ld_drop   = ld_wr & ~ld_accept;

  // ---------------------------------------------------------------------------
  // RAM write port: one cycle behind the bus write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= cnt_inc;
      if (ld_accept) begin
        mem_addr  <= sel_cnt;
        mem_wdata <= writedata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, start pulses, error flag and result pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    layer_next = layer_idx;
    start_next = '0;
    err_next   = err;
    ptr_next   = ptr;

    if (cmd_restart || cmd_rerun) begin
      // Any in-flight run is abandoned; late done pulses land in LOAD and
      // are ignored there.
      state_next = LOAD;
      layer_next = '0;
      ptr_next   = '0;
      if (cmd_restart) begin
        err_next = 1'b0;
      end
    end else begin
      if (ld_drop) begin
        err_next = 1'b1;
      end
      case (state)
        LOAD: begin
          if (&loaded) begin
            state_next = RUN;
            layer_next = '0;
            start_next = 4'b0001;
          end
        end
        RUN: begin
          // A done from any layer other than the active one is a fault.
          if ((layer_done & ~(4'b0001 << layer_idx)) != 4'b0000) begin
            err_next = 1'b1;
          end
          if (layer_done[layer_idx]) begin
            if (layer_idx == 2'(N_LAYERS - 1)) begin
              state_next = DONE;
            end else begin
              layer_next = layer_idx + 2'd1;
              start_next = 4'b0001 << (layer_idx + 2'd1);
            end
          end
        end
        DONE: begin
          if (rd_only && address == ADDR_RESULT) begin
            ptr_next = (ptr == OUT_LAST) ? '0 : ptr + ADDR_W'(1);
          end
        end
        default: begin
          state_next = LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      layer_idx   <= '0;
      layer_start <= '0;
      err         <= 1'b0;
      ptr         <= '0;
    end else begin
      state       <= state_next;
      layer_idx   <= layer_next;
      layer_start <= start_next;
      err         <= err_next;
      ptr         <= ptr_next;
    end
  end

  // The result RAM is read continuously at the pointer, so a read returns the
  // byte fetched for the pointer value of the previous cycle. Reads closer
  // than two cycles therefore repeat the earlier byte.
  assign out_rd_addr = ptr;

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  logic [7:0] status_byte;

  always_comb begin
    status_byte            = '0;
    status_byte[STAT_BUSY] = (state == RUN);
    status_byte[STAT_DONE] = (state == DONE);
    status_byte[STAT_ERR]  = err;
    status_byte[N_REGIONS-1:0] = loaded;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= '0;
      if (rd_only) begin
        if (address == ADDR_STATUS) begin
          readdata <= status_byte;
        end else if (address == ADDR_RESULT && state == DONE) begin
          readdata <= out_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer with small region sizes.
// Expected RAM writes and expected read data are queued when stimulus is
// driven and compared when the DUT produces them.
module tb_cnn_layer_sequencer;

  localparam int ADDR_W = 19;
  localparam int SIZES [5] = '{4, 2, 2, 2, 2};

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect, write, read;
  logic [2:0]        address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic [4:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [3:0]        layer_start;
  logic [3:0]        layer_done;
  logic [ADDR_W-1:0] out_rd_addr;
  logic [7:0]        out_rd_data;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .ADDR_W   (ADDR_W),
    .IN_SIZE  (4),
    .L1_SIZE  (2),
    .L2_SIZE  (2),
    .L3_SIZE  (2),
    .L4_SIZE  (2),
    .OUT_SIZE (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .out_rd_addr (out_rd_addr),
    .out_rd_data (out_rd_data)
  );

  // Result RAM with registered read.
  logic [7:0] out_ram [3] = '{8'hA0, 8'hA1, 8'hA2};
  always @(posedge clk)
    out_rd_data <= (out_rd_addr < 3) ? out_ram[out_rd_addr[1:0]] : 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards
  // ---------------------------------------------------------------------------
  typedef struct {
    int                region;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } mem_exp_t;

  typedef struct {
    string      tag;
    logic [7:0] data;
  } rd_exp_t;

  mem_exp_t mem_q [$];
  rd_exp_t  rd_q  [$];

  // Independent model of the load counters.
  int model_cnt    [5];
  bit model_loaded [5];
  bit model_loading;

  int start_cnt [4] = '{0, 0, 0, 0};
  logic rd_at_edge = 1'b0;

  always @(posedge clk) rd_at_edge <= chipselect & read;

  always @(negedge clk) begin
    if (mem_we != 5'b0) begin
      if (mem_q.size() == 0) begin
        check("mem_we_unexpected", mem_we, 5'b0);
      end else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        check("mem_we", mem_we, 5'b1 << e.region);
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.data);
      end
    end
    if (rd_at_edge) begin
      if (rd_q.size() == 0) begin
        check("readdata_unexpected", 1, 0);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        check(r.tag, readdata, r.data);
      end
    end
    for (int i = 0; i < 4; i++)
      if (layer_start[i]) start_cnt[i]++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset_all();
    for (int r = 0; r < 5; r++) begin
      model_cnt[r]    = 0;
      model_loaded[r] = 1'b0;
    end
    model_loading = 1'b1;
  endtask

  task automatic load_write(input int r, input logic [7:0] d, input bit with_read);
    if (model_loading && !model_loaded[r]) begin
      mem_q.push_back('{region: r, addr: ADDR_W'(model_cnt[r]), data: d});
      if (model_cnt[r] == SIZES[r] - 1) model_loaded[r] = 1'b1;
      else model_cnt[r]++;
    end
    if (with_read) rd_q.push_back('{tag: "rw_readdata", data: 8'h00});
    chipselect = 1'b1;
    write      = 1'b1;
    read       = with_read;
    address    = 3'(r);
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic cmd_write(input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 3'd7;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
    rd_q.push_back('{tag: tag, data: exp});
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic pulse_done(input int k);
    layer_done = 4'b0001 << k;
    tick();
    layer_done = 4'b0000;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_readdata"}, readdata, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_layer_start"}, layer_start, 0);
    check({tag, "_out_rd_addr"}, out_rd_addr, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 3'd0;
    writedata  = 8'h00;
    layer_done = 4'b0000;
    model_reset_all();

    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    bus_read(3'd5, 8'h00, "status_after_reset");

    // Input image, back-to-back.
    for (int i = 0; i < 4; i++) load_write(0, 8'h11 + 8'(i), 1'b0);
    tick();
    bus_read(3'd5, 8'h01, "status_input_loaded");

    // Weight regions; the last byte completes the load.
    for (int r = 1; r < 5; r++)
      for (int i = 0; i < 2; i++) load_write(r, 8'h30 + 8'(r * 16 + i), 1'b0);
    tick();
    check("start0_after_load", layer_start, 4'b0001);
    model_loading = 1'b0;
    tick();
    check("start0_single_cycle", layer_start, 4'b0000);
    bus_read(3'd5, 8'h9F, "status_run0");

    for (int k = 0; k < 3; k++) begin
      pulse_done(k);
      check($sformatf("start%0d_after_done%0d", k + 1, k), layer_start, 4'b0001 << (k + 1));
    end
    pulse_done(3);
    check("no_start_after_done3", layer_start, 4'b0000);
    bus_read(3'd5, 8'h5F, "status_done");

    // Result stream, reads two cycles apart, wrapping at OUT_SIZE.
    bus_read(3'd6, 8'hA0, "result0"); tick();
    bus_read(3'd6, 8'hA1, "result1"); tick();
    bus_read(3'd6, 8'hA2, "result2"); tick();
    bus_read(3'd6, 8'hA0, "result_wrap"); tick();
    check("ptr_after_wrap", out_rd_addr, 1);
    // Back-to-back reads: the second repeats the previous byte.
    bus_read(3'd6, 8'hA1, "result_b2b_first");
    bus_read(3'd6, 8'hA1, "result_b2b_repeat");
    tick();
    bus_read(3'd6, 8'hA0, "result_after_b2b");
    bus_read(3'd0, 8'h00, "read_region_addr");

    // Rerun: only the image is reloaded.
    cmd_write(8'h02);
    model_cnt[0]    = 0;
    model_loaded[0] = 1'b0;
    model_loading   = 1'b1;
    check("ptr_after_rerun", out_rd_addr, 0);
    bus_read(3'd5, 8'h1E, "status_after_rerun");
    bus_read(3'd6, 8'h00, "result_outside_done");
    load_write(0, 8'h21, 1'b1);
    for (int i = 1; i < 4; i++) load_write(0, 8'h21 + 8'(i), 1'b0);
    tick();
    check("start0_after_rerun", layer_start, 4'b0001);
    model_loading = 1'b0;

    // Faults during RUN(0): write to a full region, stray done from layer 2.
    load_write(1, 8'h55, 1'b0);
    pulse_done(2);
    check("no_start_on_stray_done", layer_start, 4'b0000);
    bus_read(3'd5, 8'hBF, "status_err_run0");
    pulse_done(0);
    check("start1_after_err", layer_start, 4'b0010);

    // Reset in RUN(1); a late done must be ignored.
    reset = 1'b1;
    tick();
    check_outputs_zero("midrun_reset");
    reset = 1'b0;
    model_reset_all();
    bus_read(3'd5, 8'h00, "status_after_midrun_reset");
    pulse_done(1);
    check("no_start_late_done", layer_start, 4'b0000);
    bus_read(3'd5, 8'h00, "status_late_done");
    tick();

    check("start_count_0", start_cnt[0], 2);
    check("start_count_1", start_cnt[1], 2);
    check("start_count_2", start_cnt[2], 1);
    check("start_count_3", start_cnt[3], 1);
    check("mem_queue_drained", mem_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
